// File: rtl/isdu_control.sv
// Instruction-sequencing control FSM for the SLC-3 CPU.
// Outputs are registered from the decoded next state so they line up with the state register.
module isdu_control (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic       Continue,
  input  logic [3:0] Opcode,
  input  logic       IR_5,
  input  logic       IR_11,
  input  logic       BEN,
  output logic       LD_MAR,
  output logic       LD_MDR,
  output logic       LD_IR,
  output logic       LD_BEN,
  output logic       LD_CC,
  output logic       LD_REG,
  output logic       LD_PC,
  output logic       LD_LED,
  output logic       GatePC,
  output logic       GateMDR,
  output logic       GateALU,
  output logic       GateMARMUX,
  output logic [1:0] PCMUX,
  output logic [1:0] ADDR2MUX,
  output logic [1:0] ALUK,
  output logic       DRMUX,
  output logic       SR1MUX,
  output logic       SR2MUX,
  output logic       ADDR1MUX,
  output logic       MIO_EN,
  output logic       Mem_CE,
  output logic       Mem_UB,
  output logic       Mem_LB,
  output logic       Mem_OE,
  output logic       Mem_WE
);

  typedef enum logic [4:0] {
    StHalted,
    St18,
    St33_1,
    St33_2,
    St35,
    St32,
    St01,
    St05,
    St09,
    St00,
    St22,
    St12,
    St04,
    St21,
    St20,
    St06,
    St25_1,
    St25_2,
    St27,
    St07,
    St23,
    St16_1,
    St16_2,
    StPauseIr1,
    StPauseIr2
  } state_e;

  state_e r_state;
  state_e w_state_next;

  logic       w_ld_mar, w_ld_mdr, w_ld_ir, w_ld_ben, w_ld_cc, w_ld_reg, w_ld_pc, w_ld_led;
  logic       w_gate_pc, w_gate_mdr, w_gate_alu, w_gate_marmux;
  logic [1:0] w_pcmux, w_addr2mux, w_aluk;
  logic       w_drmux, w_sr1mux, w_sr2mux, w_addr1mux, w_mio_en;
  logic       w_mem_oe, w_mem_we;

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StHalted:   if (Run) w_state_next = St18;
      St18:       w_state_next = St33_1;
      St33_1:     w_state_next = St33_2;
      St33_2:     w_state_next = St35;
      St35:       w_state_next = St32;
      St32: begin
        unique case (Opcode)
          4'b0001: w_state_next = St01;
          4'b0101: w_state_next = St05;
          4'b1001: w_state_next = St09;
          4'b0000: w_state_next = St00;
          4'b1100: w_state_next = St12;
          4'b0100: w_state_next = St04;
          4'b0110: w_state_next = St06;
          4'b0111: w_state_next = St07;
          4'b1101: w_state_next = StPauseIr1;
          default: w_state_next = St18;
        endcase
      end
      St00:       w_state_next = BEN ? St22 : St18;
      St04:       w_state_next = IR_11 ? St21 : St20;
      St06:       w_state_next = St25_1;
      St25_1:     w_state_next = St25_2;
      St25_2:     w_state_next = St27;
      St07:       w_state_next = St23;
      St23:       w_state_next = St16_1;
      St16_1:     w_state_next = St16_2;
      // Two-phase handshake: one instruction per press/release of Continue.
      StPauseIr1: if (Continue) w_state_next = StPauseIr2;
      StPauseIr2: if (!Continue) w_state_next = St18;
      St01, St05, St09, St22, St12, St21, St20, St27, St16_2: w_state_next = St18;
      default:    w_state_next = StHalted;
    endcase
  end

  always_comb begin
    w_ld_mar      = 1'b0;
    w_ld_mdr      = 1'b0;
    w_ld_ir       = 1'b0;
    w_ld_ben      = 1'b0;
    w_ld_cc       = 1'b0;
    w_ld_reg      = 1'b0;
    w_ld_pc       = 1'b0;
    w_ld_led      = 1'b0;
    w_gate_pc     = 1'b0;
    w_gate_mdr    = 1'b0;
    w_gate_alu    = 1'b0;
    w_gate_marmux = 1'b0;
    w_pcmux       = 2'd0;
    w_addr2mux    = 2'd0;
    w_aluk        = 2'd0;
    w_drmux       = 1'b0;
    w_sr1mux      = 1'b0;
    w_sr2mux      = 1'b0;
    w_addr1mux    = 1'b0;
    w_mio_en      = 1'b0;
    w_mem_oe      = 1'b1;
    w_mem_we      = 1'b1;
    unique case (w_state_next)
      St18: begin
        w_gate_pc = 1'b1;
        w_ld_mar  = 1'b1;
        w_pcmux   = 2'd2;
        w_ld_pc   = 1'b1;
      end
      St33_1, St25_1: begin
        w_mem_oe = 1'b0;
        w_mio_en = 1'b1;
      end
      St33_2, St25_2: begin
        w_mem_oe = 1'b0;
        w_mio_en = 1'b1;
        w_ld_mdr = 1'b1;
      end
      St35: begin
        w_gate_mdr = 1'b1;
        w_ld_ir    = 1'b1;
      end
      St32: w_ld_ben = 1'b1;
      St01, St05: begin
        w_sr1mux   = 1'b1;
        w_sr2mux   = ~IR_5;
        w_aluk     = (w_state_next == St05) ? 2'd1 : 2'd0;
        w_gate_alu = 1'b1;
        w_ld_reg   = 1'b1;
        w_ld_cc    = 1'b1;
      end
      St09: begin
        w_sr1mux   = 1'b1;
        w_aluk     = 2'd2;
        w_gate_alu = 1'b1;
        w_ld_reg   = 1'b1;
        w_ld_cc    = 1'b1;
      end
      St22: begin
        w_addr1mux = 1'b1;
        w_addr2mux = 2'd1;
        w_pcmux    = 2'd1;
        w_ld_pc    = 1'b1;
      end
      St12, St20: begin
        w_sr1mux   = 1'b1;
        w_aluk     = 2'd3;
        w_gate_alu = 1'b1;
        w_pcmux    = 2'd0;
        w_ld_pc    = 1'b1;
      end
      St04: begin
        w_gate_pc = 1'b1;
        w_drmux   = 1'b1;
        w_ld_reg  = 1'b1;
      end
      St21: begin
        w_addr1mux = 1'b1;
        w_addr2mux = 2'd0;
        w_pcmux    = 2'd1;
        w_ld_pc    = 1'b1;
      end
      St06, St07: begin
        w_sr1mux      = 1'b1;
        w_addr1mux    = 1'b0;
        w_addr2mux    = 2'd2;
        w_gate_marmux = 1'b1;
        w_ld_mar      = 1'b1;
      end
      St27: begin
        w_gate_mdr = 1'b1;
        w_ld_reg   = 1'b1;
        w_ld_cc    = 1'b1;
      end
      St23: begin
        w_sr1mux   = 1'b0;
        w_aluk     = 2'd3;
        w_gate_alu = 1'b1;
        w_mio_en   = 1'b0;
        w_ld_mdr   = 1'b1;
      end
      St16_1, St16_2: w_mem_we = 1'b0;
      StPauseIr1:     w_ld_led = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state    <= StHalted;
      LD_MAR     <= 1'b0;
      LD_MDR     <= 1'b0;
      LD_IR      <= 1'b0;
      LD_BEN     <= 1'b0;
      LD_CC      <= 1'b0;
      LD_REG     <= 1'b0;
      LD_PC      <= 1'b0;
      LD_LED     <= 1'b0;
      GatePC     <= 1'b0;
      GateMDR    <= 1'b0;
      GateALU    <= 1'b0;
      GateMARMUX <= 1'b0;
      PCMUX      <= 2'd0;
      ADDR2MUX   <= 2'd0;
      ALUK       <= 2'd0;
      DRMUX      <= 1'b0;
      SR1MUX     <= 1'b0;
      SR2MUX     <= 1'b0;
      ADDR1MUX   <= 1'b0;
      MIO_EN     <= 1'b0;
      Mem_CE     <= 1'b0;
      Mem_UB     <= 1'b0;
      Mem_LB     <= 1'b0;
      Mem_OE     <= 1'b1;
      Mem_WE     <= 1'b1;
    end else begin
      r_state    <= w_state_next;
      LD_MAR     <= w_ld_mar;
      LD_MDR     <= w_ld_mdr;
      LD_IR      <= w_ld_ir;
      LD_BEN     <= w_ld_ben;
      LD_CC      <= w_ld_cc;
      LD_REG     <= w_ld_reg;
      LD_PC      <= w_ld_pc;
      LD_LED     <= w_ld_led;
      GatePC     <= w_gate_pc;
      GateMDR    <= w_gate_mdr;
      GateALU    <= w_gate_alu;
      GateMARMUX <= w_gate_marmux;
      PCMUX      <= w_pcmux;
      ADDR2MUX   <= w_addr2mux;
      ALUK       <= w_aluk;
      DRMUX      <= w_drmux;
      SR1MUX     <= w_sr1mux;
      SR2MUX     <= w_sr2mux;
      ADDR1MUX   <= w_addr1mux;
      MIO_EN     <= w_mio_en;
      Mem_CE     <= 1'b0;
      Mem_UB     <= 1'b0;
      Mem_LB     <= 1'b0;
      Mem_OE     <= w_mem_oe;
      Mem_WE     <= w_mem_we;
    end
  end

endmodule
